// File: rtl/fmpadding_frame_ctrl.sv
// Per-frame sequencer for one fmpadding instance: programs geometry,
// gates the padder handshakes to exact beat counts, resets between frames.
module fmpadding_frame_ctrl #(
    parameter int XCOUNTER_BITS = 16,
    parameter int YCOUNTER_BITS = 16,
    parameter int NUM_CHANNELS  = 1,
    parameter int SIMD          = 1
) (
    input  logic                                         ap_clk,
    input  logic                                         ap_rst,
    input  logic                                         s_cfg_tvalid,
    output logic                                         s_cfg_tready,
    input  logic [3*XCOUNTER_BITS+3*YCOUNTER_BITS-1:0]   s_cfg_tdata,
    input  logic                                         up_tvalid,
    output logic                                         up_tready,
    output logic                                         pad_s_tvalid,
    input  logic                                         pad_s_tready,
    input  logic                                         pad_m_tvalid,
    output logic                                         pad_m_tready,
    output logic                                         m_axis_tvalid,
    input  logic                                         m_axis_tready,
    output logic                                         pad_rst_n,
    output logic                                         we,
    output logic [4:0]                                   wa,
    output logic [31:0]                                  wd,
    output logic                                         busy,
    output logic                                         frame_done
);

    localparam int SF       = NUM_CHANNELS / SIMD;
    localparam int CNT_BITS = XCOUNTER_BITS + YCOUNTER_BITS + $clog2(SF) + 1;
    localparam int XB       = XCOUNTER_BITS;
    localparam int YB       = YCOUNTER_BITS;
    localparam logic [CNT_BITS-1:0] ONE    = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] SF_CNT = CNT_BITS'(SF);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        CALC,
        RUN
    } state_t;

    state_t state, state_nxt;
    logic [2:0] k, k_nxt;

    logic [XB-1:0] x_on, x_off, x_end;
    logic [YB-1:0] y_on, y_off, y_end;

    logic [CNT_BITS-1:0] in_cnt, out_cnt, in_tgt, out_tgt;
    logic [CNT_BITS-1:0] x_lim, y_lim, x_cap, y_cap, xw, yh;
    logic [CNT_BITS-1:0] in_tgt_c, out_tgt_c;

    logic cfg_hs, ig, og, in_hs, out_hs, do_calc;

    // State register and write index
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state <= IDLE;
            k     <= 3'd0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
        end
    end

    // Next state, gates and parameter-port outputs
    always_comb begin
        state_nxt     = state;
        k_nxt         = k;
        s_cfg_tready  = 1'b0;
        pad_rst_n     = 1'b0;
        we            = 1'b0;
        wa            = 5'd0;
        wd            = 32'd0;
        busy          = 1'b1;
        ig            = 1'b0;
        og            = 1'b0;
        do_calc       = 1'b0;
        frame_done    = 1'b0;
        unique case (state)
            IDLE: begin
                busy         = 1'b0;
                s_cfg_tready = 1'b1;
                if (s_cfg_tvalid) begin
                    state_nxt = WRITE;
                    k_nxt     = 3'd0;
                end
            end
            WRITE: begin
                we = 1'b1;
                wa = {k, 2'b00};
                unique case (k)
                    3'd0:    wd = 32'(x_on);
                    3'd1:    wd = 32'(x_off);
                    3'd2:    wd = 32'(x_end);
                    3'd3:    wd = 32'(y_on);
                    3'd4:    wd = 32'(y_off);
                    default: wd = 32'(y_end);
                endcase
                k_nxt = k + 3'd1;
                if (k == 3'd5) begin
                    state_nxt = CALC;
                    k_nxt     = 3'd0;
                end
            end
            CALC: begin
                pad_rst_n = 1'b1;
                do_calc   = 1'b1;
                state_nxt = RUN;
            end
            default: begin
                pad_rst_n = 1'b1;
                ig        = (in_cnt != in_tgt);
                og        = (out_cnt != out_tgt);
            end
        endcase

        pad_s_tvalid  = up_tvalid && ig;
        up_tready     = pad_s_tready && ig;
        m_axis_tvalid = pad_m_tvalid && og;
        pad_m_tready  = m_axis_tready && og;
        cfg_hs        = s_cfg_tvalid && s_cfg_tready;
        in_hs         = pad_s_tvalid && pad_s_tready;
        out_hs        = m_axis_tvalid && m_axis_tready;

        if (state == RUN && out_hs && (out_cnt + ONE == out_tgt)) begin
            frame_done = 1'b1;
            state_nxt  = IDLE;
        end
    end

    // Beat targets: full padded frame out, clipped image window in
    always_comb begin
        x_lim     = CNT_BITS'(x_end) + ONE;
        y_lim     = CNT_BITS'(y_end) + ONE;
        x_cap     = (CNT_BITS'(x_off) < x_lim) ? CNT_BITS'(x_off) : x_lim;
        y_cap     = (CNT_BITS'(y_off) < y_lim) ? CNT_BITS'(y_off) : y_lim;
        xw        = (x_cap > CNT_BITS'(x_on)) ? x_cap - CNT_BITS'(x_on) : '0;
        yh        = (y_cap > CNT_BITS'(y_on)) ? y_cap - CNT_BITS'(y_on) : '0;
        in_tgt_c  = xw * yh * SF_CNT;
        out_tgt_c = x_lim * y_lim * SF_CNT;
    end

    // Descriptor latch, targets and beat counters
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            x_on    <= '0;
            x_off   <= '0;
            x_end   <= '0;
            y_on    <= '0;
            y_off   <= '0;
            y_end   <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
            in_tgt  <= '0;
            out_tgt <= '0;
        end else begin
            if (cfg_hs) begin
                x_on  <= s_cfg_tdata[0*XB +: XB];
                x_off <= s_cfg_tdata[1*XB +: XB];
                x_end <= s_cfg_tdata[2*XB +: XB];
                y_on  <= s_cfg_tdata[3*XB + 0*YB +: YB];
                y_off <= s_cfg_tdata[3*XB + 1*YB +: YB];
                y_end <= s_cfg_tdata[3*XB + 2*YB +: YB];
            end
            if (do_calc) begin
                in_tgt  <= in_tgt_c;
                out_tgt <= out_tgt_c;
                in_cnt  <= '0;
                out_cnt <= '0;
            end else if (state == RUN) begin
                if (in_hs)
                    in_cnt <= in_cnt + ONE;
                if (out_hs)
                    out_cnt <= out_cnt + ONE;
            end
        end
    end

endmodule
